eth_phy_link_ctrl: RTL and testbench
====================================

Name: eth_phy_link_ctrl

Overview:
- Bring-up and supervision controller for eth_phy_10g in the serdes-loopback environment.
- Resets the PHY TX side and waits for rx_block_lock, then runs a PRBS31 self-test through the PHY and waits for rx_status.
- Once the link is up, passes user XGMII traffic to the PHY and monitors for link loss.
- Retries bring-up a bounded number of times, then latches a fault.

Parameters:
- DATA_WIDTH, 64, XGMII data width.
- CTRL_WIDTH, DATA_WIDTH/8, XGMII control width.
- RST_CYCLES, 4, tx_rst_req pulse length in cycles.
- LOCK_TIMEOUT, 1024, cycles allowed in WAIT_LOCK.
- PRBS_SETTLE, 4, PRBS cycles at test start whose errors are ignored.
- PRBS_CYCLES, 256, total PRBS test length including settle.
- STATUS_TIMEOUT, 4096, cycles allowed in WAIT_STATUS.
- MAX_RETRIES, 3, failed attempts before FAULT.

Ports:
- clk_tb  in  1  clock, shared by PHY rx_clk and tx_clk.
- rx_rst_tb  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle bring-up request.
- rx_block_lock  in  1  from PHY.
- rx_high_ber  in  1  from PHY.
- rx_status  in  1  from PHY.
- serdes_rx_reset_req  in  1  from PHY.
- rx_error_count  in  7  from PHY; per-cycle PRBS bit-error count.
- user_txd  in  DATA_WIDTH  user XGMII data.
- user_txc  in  CTRL_WIDTH  user XGMII control.
- user_valid  in  1  user word is valid this cycle.
- xgmii_txd  out  DATA_WIDTH  to PHY.
- xgmii_txc  out  CTRL_WIDTH  to PHY.
- cfg_tx_prbs31_enable  out  1  to PHY.
- cfg_rx_prbs31_enable  out  1  to PHY.
- tx_rst_req  out  1  drives PHY tx_rst.
- state  out  3  current FSM state encoding.
- link_up  out  1  high only in LINK_UP.
- fault  out  1  high only in FAULT.
- prbs_err_total  out  16  saturating PRBS error sum of the last test.
- retry_cnt  out  2  failed attempts so far.

Behaviour:
- All outputs registered. Reset values:
  - xgmii_txd=64'h0707070707070707, xgmii_txc=8'hFF (IDLE).
  - cfg enables=0, tx_rst_req=0, state=IDLE(0), link_up=0, fault=0, prbs_err_total=0, retry_cnt=0.
- State encoding: IDLE=0, RESET=1, WAIT_LOCK=2, PRBS=3, WAIT_STATUS=4, LINK_UP=5, FAULT=6.
- IDLE: start -> RESET. retry_cnt and prbs_err_total are cleared on that edge.
- RESET:
  - tx_rst_req is high for exactly RST_CYCLES cycles.
  - Then -> WAIT_LOCK with the timer cleared.
- WAIT_LOCK:
  - rx_block_lock=1 -> PRBS. Cycle counter and prbs_err_total cleared.
  - Timer reaching LOCK_TIMEOUT-1 with no lock -> FAIL.
- PRBS:
  - Both cfg enables high for all PRBS_CYCLES cycles; xgmii outputs hold IDLE.
  - From cycle PRBS_SETTLE onward, rx_error_count is added to prbs_err_total, saturating at 16'hFFFF.
  - After the last cycle, both enables drop. prbs_err_total==0 -> WAIT_STATUS, else FAIL.
- WAIT_STATUS:
  - rx_status=1 -> LINK_UP.
  - Timer reaching STATUS_TIMEOUT-1 -> FAIL.
  - rx_block_lock falling -> FAIL immediately.
- LINK_UP:
  - link_up=1.
  - Registered mux: if user_valid then xgmii_txd/txc = user_txd/user_txc, else IDLE; one cycle latency.
  - Any of rx_block_lock=0, rx_high_ber=1, serdes_rx_reset_req=1 -> FAIL.
  - start is ignored.
- FAIL (transient action, not a state):
  - retry_cnt += 1. If the new value == MAX_RETRIES -> FAULT, else -> RESET.
  - xgmii outputs return to IDLE on the same edge.
- FAULT:
  - fault=1, outputs IDLE, cfg enables 0.
  - start -> RESET with retry_cnt cleared.
- start is ignored in all states other than IDLE and FAULT.
- In WAIT_LOCK, lock and timeout on the same cycle: lock wins.
- retry_cnt never exceeds MAX_RETRIES.
- Reset asserted mid-operation returns everything to reset values asynchronously. Any PRBS test in progress is aborted with no FAIL counted.

Decomposition:
- Package eth_phy_ctrl_pkg holds:
  - state encodings;
  - XGMII_IDLE_D=64'h0707070707070707 and XGMII_IDLE_C=8'hFF;
  - counter widths derived with $clog2 of the timeouts.
- One sub-module, eth_phy_ctrl_timer: loadable down-counter with done flag, shared by the RESET, WAIT_LOCK, PRBS and WAIT_STATUS states.

Test Plan:
- Healthy loopback: serdes_tx registered into serdes_rx, then start pulse -> state sequence 1,2,3,4,5; prbs_err_total=0; link_up=1; retry_cnt=0.
- Traffic: in LINK_UP with user_valid=1, user_txd=64'hFEFEFEFEFEFEFEFE, user_txc=8'h00 -> xgmii_txd equals that value one cycle later. user_valid=0 -> 64'h0707070707070707 / 8'hFF.
- Broken loopback: serdes_rx_hdr forced to 2'b00 -> each attempt times out in WAIT_LOCK; after 3 attempts fault=1, state=6, retry_cnt=3.
- PRBS errors: one bit of serdes_rx_data inverted during PRBS -> prbs_err_total>0, FAIL, retry_cnt=1, state back to RESET.
- Link loss: rx_block_lock forced low for 1 cycle in LINK_UP -> link_up=0 next cycle, retry_cnt=1, full re-bring-up succeeds.
- Async reset asserted mid-PRBS -> cfg enables=0, state=0, xgmii outputs at IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/eth_phy_ctrl_pkg.sv
// Shared types and constants for the eth_phy_10g bring-up/supervision controller.
// Holds the FSM state encoding, the XGMII idle pattern and counter-width helpers.
package eth_phy_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RESET       = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_PRBS        = 3'd3,
    ST_WAIT_STATUS = 3'd4,
    ST_LINK_UP     = 3'd5,
    ST_FAULT       = 3'd6
  } state_t;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned ERR_CNT_W  = 7;
  localparam int unsigned PRBS_SUM_W = 16;

  localparam logic [63:0] XGMII_IDLE_D = 64'h0707070707070707;
  localparam logic [7:0]  XGMII_IDLE_C = 8'hFF;

  localparam int unsigned DEF_RST_CYCLES     = 4;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 1024;
  localparam int unsigned DEF_PRBS_SETTLE    = 4;
  localparam int unsigned DEF_PRBS_CYCLES    = 256;
  localparam int unsigned DEF_STATUS_TIMEOUT = 4096;
  localparam int unsigned DEF_MAX_RETRIES    = 3;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Shared timer width for the default timeouts (largest load value is timeout-1).
  localparam int unsigned DEF_TIMER_W = cnt_width(max_of4(DEF_RST_CYCLES, DEF_LOCK_TIMEOUT,
                                                          DEF_PRBS_CYCLES, DEF_STATUS_TIMEOUT) - 1);

endpackage

// File: rtl/eth_phy_ctrl_timer.sv
// Loadable down-counter shared by the controller's timed states.
// Ports: clk_tb/rx_rst_tb clock and async active-high reset; load/load_val preset
// the count (load wins over dec); dec counts down and holds at zero;
// count is the registered value; done_c is high while count is zero.
module eth_phy_ctrl_timer #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk_tb,
  input  logic             rx_rst_tb,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             done_c
);

  assign done_c = (count == '0);

  always_ff @(posedge clk_tb or posedge rx_rst_tb) begin
    if (rx_rst_tb) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !done_c) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/eth_phy_link_ctrl.sv
// Bring-up and supervision controller for eth_phy_10g.
// Resets the PHY TX side, waits for block lock, runs a PRBS31 self-test, waits for
// rx_status, then forwards user XGMII traffic while watching for link loss.
// Failed attempts retry bring-up up to MAX_RETRIES times before latching FAULT.
// Ports:
//   clk_tb, rx_rst_tb            clock and async active-high reset
//   start                        single-cycle bring-up request (IDLE/FAULT only)
//   rx_block_lock, rx_high_ber, rx_status, serdes_rx_reset_req, rx_error_count  PHY status
//   user_txd/user_txc/user_valid user XGMII word
//   xgmii_txd/xgmii_txc          registered XGMII to PHY (IDLE outside LINK_UP)
//   cfg_tx/rx_prbs31_enable      PRBS self-test enables
//   tx_rst_req                   PHY TX reset request
//   state, link_up, fault, prbs_err_total, retry_cnt  status
module eth_phy_link_ctrl
  import eth_phy_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned PRBS_SETTLE    = DEF_PRBS_SETTLE,
  parameter int unsigned PRBS_CYCLES    = DEF_PRBS_CYCLES,
  parameter int unsigned STATUS_TIMEOUT = DEF_STATUS_TIMEOUT,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
  localparam int unsigned RETRY_W       = cnt_width(MAX_RETRIES)
) (
  input  logic                  clk_tb,
  input  logic                  rx_rst_tb,
  input  logic                  start,
  input  logic                  rx_block_lock,
  input  logic                  rx_high_ber,
  input  logic                  rx_status,
  input  logic                  serdes_rx_reset_req,
  input  logic [ERR_CNT_W-1:0]  rx_error_count,
  input  logic [DATA_WIDTH-1:0] user_txd,
  input  logic [CTRL_WIDTH-1:0] user_txc,
  input  logic                  user_valid,
  output logic [DATA_WIDTH-1:0] xgmii_txd,
  output logic [CTRL_WIDTH-1:0] xgmii_txc,
  output logic                  cfg_tx_prbs31_enable,
  output logic                  cfg_rx_prbs31_enable,
  output logic                  tx_rst_req,
  output logic [STATE_W-1:0]    state,
  output logic                  link_up,
  output logic                  fault,
  output logic [PRBS_SUM_W-1:0] prbs_err_total,
  output logic [RETRY_W-1:0]    retry_cnt
);

  localparam int unsigned TIMER_W = cnt_width(max_of4(RST_CYCLES, LOCK_TIMEOUT,
                                                      PRBS_CYCLES, STATUS_TIMEOUT) - 1);
  localparam int unsigned SUM_W   = PRBS_SUM_W + 1;

  localparam logic [DATA_WIDTH-1:0] IDLE_D = {CTRL_WIDTH{XGMII_IDLE_D[7:0]}};
  localparam logic [CTRL_WIDTH-1:0] IDLE_C = {CTRL_WIDTH{XGMII_IDLE_C[0]}};

  localparam logic [TIMER_W-1:0] RST_LOAD    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] PRBS_LOAD   = TIMER_W'(PRBS_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STATUS_LOAD = TIMER_W'(STATUS_TIMEOUT - 1);
  // Timer counts down through the test, so cycles >= PRBS_SETTLE have count <= ACC_LAST.
  localparam logic [TIMER_W-1:0] ACC_LAST    = TIMER_W'(PRBS_CYCLES - 1 - PRBS_SETTLE);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] txd_d;
  logic [CTRL_WIDTH-1:0] txc_d;
  logic                  prbs_en_d, tx_rst_d, link_up_d, fault_d, fail;
  logic [PRBS_SUM_W-1:0] prbs_sum_d, sum_sat;
  logic [SUM_W-1:0]      sum_wide;
  logic [RETRY_W-1:0]    retry_d, retry_inc;
  logic                  tmr_load, tmr_dec, tmr_done;
  logic [TIMER_W-1:0]    tmr_val, tmr_count;

  eth_phy_ctrl_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk_tb    (clk_tb),
    .rx_rst_tb (rx_rst_tb),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .dec       (tmr_dec),
    .count     (tmr_count),
    .done_c    (tmr_done)
  );

  // Saturating PRBS error accumulation.
  assign sum_wide  = {1'b0, prbs_err_total} + SUM_W'(rx_error_count);
  assign sum_sat   = sum_wide[SUM_W-1] ? '1 : sum_wide[PRBS_SUM_W-1:0];
  assign retry_inc = retry_cnt + RETRY_W'(1);
  assign state     = state_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    txd_d      = IDLE_D;
    txc_d      = IDLE_C;
    prbs_en_d  = 1'b0;
    tx_rst_d   = 1'b0;
    prbs_sum_d = prbs_err_total;
    retry_d    = retry_cnt;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;
    fail       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RESET;
          retry_d    = '0;
          prbs_sum_d = '0;
          tmr_load   = 1'b1;
          tmr_val    = RST_LOAD;
          tx_rst_d   = 1'b1;
        end
      end
      ST_RESET: begin
        tmr_dec  = 1'b1;
        tx_rst_d = 1'b1;
        if (tmr_done) begin
          state_d  = ST_WAIT_LOCK;
          tx_rst_d = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = LOCK_LOAD;
        end
      end
      ST_WAIT_LOCK: begin
        tmr_dec = 1'b1;
        // Lock is checked before the timeout so a same-cycle lock still succeeds.
        if (rx_block_lock) begin
          state_d    = ST_PRBS;
          prbs_sum_d = '0;
          prbs_en_d  = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = PRBS_LOAD;
        end else if (tmr_done) begin
          fail = 1'b1;
        end
      end
      ST_PRBS: begin
        tmr_dec   = 1'b1;
        prbs_en_d = 1'b1;
        if (tmr_count <= ACC_LAST) prbs_sum_d = sum_sat;
        if (tmr_done) begin
          prbs_en_d = 1'b0;
          if (prbs_sum_d == '0) begin
            state_d  = ST_WAIT_STATUS;
            tmr_load = 1'b1;
            tmr_val  = STATUS_LOAD;
          end else begin
            fail = 1'b1;
          end
        end
      end
      ST_WAIT_STATUS: begin
        tmr_dec = 1'b1;
        if (!rx_block_lock)  fail = 1'b1;
        else if (rx_status)  state_d = ST_LINK_UP;
        else if (tmr_done)   fail = 1'b1;
      end
      ST_LINK_UP: begin
        if (!rx_block_lock || rx_high_ber || serdes_rx_reset_req) begin
          fail = 1'b1;
        end else if (user_valid) begin
          txd_d = user_txd;
          txc_d = user_txc;
        end
      end
      ST_FAULT: begin
        if (start) begin
          state_d  = ST_RESET;
          retry_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = RST_LOAD;
          tx_rst_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Failed attempt: count it, then either retry from RESET or give up.
    if (fail) begin
      retry_d   = retry_inc;
      prbs_en_d = 1'b0;
      if (retry_inc == RETRY_W'(MAX_RETRIES)) begin
        state_d = ST_FAULT;
      end else begin
        state_d  = ST_RESET;
        tmr_load = 1'b1;
        tmr_val  = RST_LOAD;
        tx_rst_d = 1'b1;
      end
    end

    link_up_d = (state_d == ST_LINK_UP);
    fault_d   = (state_d == ST_FAULT);
  end

  // State and output registers.
  always_ff @(posedge clk_tb or posedge rx_rst_tb) begin
    if (rx_rst_tb) begin
      state_q              <= ST_IDLE;
      xgmii_txd            <= IDLE_D;
      xgmii_txc            <= IDLE_C;
      cfg_tx_prbs31_enable <= 1'b0;
      cfg_rx_prbs31_enable <= 1'b0;
      tx_rst_req           <= 1'b0;
      link_up              <= 1'b0;
      fault                <= 1'b0;
      prbs_err_total       <= '0;
      retry_cnt            <= '0;
    end else begin
      state_q              <= state_d;
      xgmii_txd            <= txd_d;
      xgmii_txc            <= txc_d;
      cfg_tx_prbs31_enable <= prbs_en_d;
      cfg_rx_prbs31_enable <= prbs_en_d;
      tx_rst_req           <= tx_rst_d;
      link_up              <= link_up_d;
      fault                <= fault_d;
      prbs_err_total       <= prbs_sum_d;
      retry_cnt            <= retry_d;
    end
  end

endmodule

// File: tb/tb_eth_phy_link_ctrl.sv
// Self-checking bench for eth_phy_link_ctrl with a small behavioural PHY model.
module tb_eth_phy_link_ctrl;

  localparam logic [63:0] IDLE_D   = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C   = 8'hFF;
  localparam int          LOCK_TO  = 1024;
  localparam int          EXP_ERR  = 256 - 4;
  localparam int          LOG_N    = 256;

  logic        clk_tb = 1'b0;
  logic        rx_rst_tb = 1'b1;
  logic        start = 1'b0;
  logic        rx_block_lock, rx_high_ber = 1'b0, rx_status, serdes_rx_reset_req = 1'b0;
  logic [6:0]  rx_error_count;
  logic [63:0] user_txd = '0;
  logic [7:0]  user_txc = '0;
  logic        user_valid = 1'b0;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic        cfg_tx_prbs31_enable, cfg_rx_prbs31_enable, tx_rst_req;
  logic [2:0]  state;
  logic        link_up, fault;
  logic [15:0] prbs_err_total;
  logic [1:0]  retry_cnt;

  eth_phy_link_ctrl dut (
    .clk_tb               (clk_tb),
    .rx_rst_tb            (rx_rst_tb),
    .start                (start),
    .rx_block_lock        (rx_block_lock),
    .rx_high_ber          (rx_high_ber),
    .rx_status            (rx_status),
    .serdes_rx_reset_req  (serdes_rx_reset_req),
    .rx_error_count       (rx_error_count),
    .user_txd             (user_txd),
    .user_txc             (user_txc),
    .user_valid           (user_valid),
    .xgmii_txd            (xgmii_txd),
    .xgmii_txc            (xgmii_txc),
    .cfg_tx_prbs31_enable (cfg_tx_prbs31_enable),
    .cfg_rx_prbs31_enable (cfg_rx_prbs31_enable),
    .tx_rst_req           (tx_rst_req),
    .state                (state),
    .link_up              (link_up),
    .fault                (fault),
    .prbs_err_total       (prbs_err_total),
    .retry_cnt            (retry_cnt)
  );

  always #5 clk_tb = ~clk_tb;

  // PHY model: lock 9 cycles after tx reset releases (if the loopback is healthy),
  // status follows lock by a cycle, one error per cycle while PRBS runs with injection.
  logic       phy_ok = 1'b1, err_inject = 1'b0, drop_lock = 1'b0, force_lock = 1'b0;
  logic [3:0] lock_ctr;
  logic       lock_q, status_q;
  logic [6:0] err_q;

  always @(posedge clk_tb or posedge rx_rst_tb) begin
    if (rx_rst_tb) begin
      lock_ctr <= '0; lock_q <= 1'b0; status_q <= 1'b0; err_q <= '0;
    end else begin
      if (tx_rst_req || !phy_ok) begin
        lock_ctr <= '0; lock_q <= 1'b0;
      end else if (lock_ctr != 4'd8) lock_ctr <= lock_ctr + 4'd1;
      else lock_q <= 1'b1;
      status_q <= rx_block_lock;
      err_q    <= (cfg_rx_prbs31_enable && err_inject) ? 7'd1 : 7'd0;
    end
  end

  assign rx_block_lock  = (lock_q | force_lock) & ~drop_lock;
  assign rx_status      = status_q;
  assign rx_error_count = err_q;

  // Monitor on the falling edge: state-change log with timestamps, level counters.
  int         cyc = 0, log_n = 0, rst_hi = 0, prbs_hi = 0;
  logic [2:0] last_s = 3'd0;
  logic [2:0] log_s [LOG_N];
  int         log_t [LOG_N];

  always @(negedge clk_tb) begin
    cyc = cyc + 1;
    if (tx_rst_req) rst_hi = rst_hi + 1;
    if (cfg_tx_prbs31_enable) prbs_hi = prbs_hi + 1;
    if (state !== last_s && log_n < LOG_N) begin
      log_s[log_n] = state;
      log_t[log_n] = cyc;
      log_n = log_n + 1;
    end
    last_s = state;
  end

  function automatic logic [2:0] log_state(input int i);
    if (i >= 0 && i < log_n) return log_s[i];
    return 3'bxxx;
  endfunction

  function automatic int log_time(input int i);
    if (i >= 0 && i < log_n) return log_t[i];
    return -1;
  endfunction

  // Scoreboard.
  typedef struct {
    string       tag;
    logic [71:0] exp;
  } sb_t;
  sb_t sb_q[$];
  int  vectors = 0, miscompares = 0;

  task automatic sb_push(input string tag, input logic [71:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [71:0] obs);
    sb_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: observed 'h%0h, no expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed 'h%0h, expected 'h%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rx_rst_tb = 1'b1;
    tick();
    tick();
    rx_rst_tb = 1'b0;
    tick();
  endtask

  // Bounded wait for a state; an expired budget shows up as a miscompare.
  task automatic expect_state_within(input string tag, input logic [2:0] tgt, input int budget);
    int n;
    sb_push(tag, 72'(tgt));
    n = 0;
    while (state !== tgt && n < budget) begin
      tick();
      n++;
    end
    sb_check(72'(state));
  endtask

  task automatic expect_val(input string tag, input logic [71:0] exp, input logic [71:0] obs);
    sb_push(tag, exp);
    sb_check(obs);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, r0, p0, n;
    logic [63:0] d;
    logic [7:0]  c;
    logic        v;

    // Reset values.
    tick();
    tick();
    expect_val("rst_state",  72'(3'd0),  72'(state));
    expect_val("rst_txd",    72'(IDLE_D), 72'(xgmii_txd));
    expect_val("rst_txc",    72'(IDLE_C), 72'(xgmii_txc));
    expect_val("rst_cfg",    72'(2'b00), 72'({cfg_tx_prbs31_enable, cfg_rx_prbs31_enable}));
    expect_val("rst_txrst",  72'(1'b0),  72'(tx_rst_req));
    expect_val("rst_flags",  72'(2'b00), 72'({link_up, fault}));
    expect_val("rst_prbs",   72'(16'h0), 72'(prbs_err_total));
    expect_val("rst_retry",  72'(2'd0),  72'(retry_cnt));
    rx_rst_tb = 1'b0;
    tick();

    // Healthy bring-up.
    n0 = log_n; r0 = rst_hi; p0 = prbs_hi;
    pulse_start();
    expect_state_within("healthy_linkup", 3'd5, 2000);
    tick();
    for (int i = 0; i < 5; i++) begin
      sb_push($sformatf("healthy_seq%0d", i), 72'(i + 1));
      sb_check(72'(log_state(n0 + i)));
    end
    expect_val("healthy_prbs",    72'(16'h0), 72'(prbs_err_total));
    expect_val("healthy_link_up", 72'(1'b1),  72'(link_up));
    expect_val("healthy_retry",   72'(2'd0),  72'(retry_cnt));
    expect_val("rst_req_cycles",  72'(4),     72'(rst_hi - r0));
    expect_val("prbs_en_cycles",  72'(256),   72'(prbs_hi - p0));

    // start is ignored in LINK_UP.
    pulse_start();
    tick();
    expect_val("start_ignored", 72'(3'd5), 72'(state));

    // Traffic with one-cycle latency.
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin d = 64'hFEFEFEFEFEFEFEFE; c = 8'h00; v = 1'b1; end
      else begin d = {$urandom(), $urandom()}; c = 8'($urandom()); v = (i != 1 && i != 4); end
      user_txd = d; user_txc = c; user_valid = v;
      sb_push($sformatf("traffic%0d", i), v ? {c, d} : {IDLE_C, IDLE_D});
      tick();
      sb_check({xgmii_txc, xgmii_txd});
    end
    user_valid = 1'b0;
    tick();

    // Link loss for one cycle, then full re-bring-up.
    drop_lock = 1'b1;
    tick();
    drop_lock = 1'b0;
    expect_val("loss_link_up", 72'(1'b0), 72'(link_up));
    expect_val("loss_state",   72'(3'd1), 72'(state));
    expect_val("loss_retry",   72'(2'd1), 72'(retry_cnt));
    expect_val("loss_txd",     72'(IDLE_D), 72'(xgmii_txd));
    expect_val("loss_txrst",   72'(1'b1), 72'(tx_rst_req));
    expect_state_within("loss_recover", 3'd5, 2000);
    expect_val("loss_recover_retry", 72'(2'd1), 72'(retry_cnt));

    // PRBS errors injected: every cycle after the first carries one error.
    do_reset();
    err_inject = 1'b1;
    pulse_start();
    expect_state_within("err_in_prbs", 3'd3, 100);
    n = 0;
    while (state === 3'd3 && n < 400) begin
      tick();
      n++;
    end
    expect_val("err_state", 72'(3'd1),    72'(state));
    expect_val("err_retry", 72'(2'd1),    72'(retry_cnt));
    expect_val("err_total", 72'(EXP_ERR), 72'(prbs_err_total));
    expect_val("err_cfg",   72'(2'b00),   72'({cfg_tx_prbs31_enable, cfg_rx_prbs31_enable}));
    err_inject = 1'b0;
    expect_state_within("err_recover", 3'd5, 2000);
    expect_val("err_recover_total", 72'(16'h0), 72'(prbs_err_total));
    expect_val("err_recover_retry", 72'(2'd1),  72'(retry_cnt));

    // Broken loopback: three lock timeouts then FAULT.
    do_reset();
    phy_ok = 1'b0;
    n0 = log_n;
    pulse_start();
    expect_state_within("broken_fault", 3'd6, 4000);
    tick();
    expect_val("broken_flag",  72'(1'b1), 72'(fault));
    expect_val("broken_retry", 72'(2'd3), 72'(retry_cnt));
    expect_val("broken_link",  72'(1'b0), 72'(link_up));
    for (int i = 0; i < 7; i++) begin
      sb_push($sformatf("broken_seq%0d", i), 72'((i == 6) ? 3'd6 : ((i % 2 == 0) ? 3'd1 : 3'd2)));
      sb_check(72'(log_state(n0 + i)));
    end
    expect_val("lock_timeout_len", 72'(LOCK_TO), 72'(log_time(n0 + 2) - log_time(n0 + 1)));

    // Restart from FAULT clears retries; lock on the final timeout cycle wins.
    pulse_start();
    expect_val("fault_restart_state", 72'(3'd1), 72'(state));
    expect_val("fault_restart_retry", 72'(2'd0), 72'(retry_cnt));
    expect_val("fault_restart_flag",  72'(1'b0), 72'(fault));
    expect_state_within("lw_wait_lock", 3'd2, 20);
    repeat (LOCK_TO - 1) tick();
    expect_val("lw_last_cycle", 72'(3'd2), 72'(state));
    force_lock = 1'b1;
    tick();
    expect_val("lw_lock_wins", 72'(3'd3), 72'(state));
    expect_state_within("lw_linkup", 3'd5, 2000);
    serdes_rx_reset_req = 1'b1;
    tick();
    serdes_rx_reset_req = 1'b0;
    expect_val("rxreq_state", 72'(3'd1), 72'(state));
    expect_val("rxreq_retry", 72'(2'd1), 72'(retry_cnt));
    force_lock = 1'b0;

    // Async reset mid-PRBS.
    do_reset();
    phy_ok = 1'b1;
    pulse_start();
    expect_state_within("ar_in_prbs", 3'd3, 100);
    repeat (20) tick();
    #2;
    rx_rst_tb = 1'b1;
    #1;
    expect_val("ar_state", 72'(3'd0),   72'(state));
    expect_val("ar_cfg",   72'(2'b00),  72'({cfg_tx_prbs31_enable, cfg_rx_prbs31_enable}));
    expect_val("ar_txd",   72'(IDLE_D), 72'(xgmii_txd));
    expect_val("ar_txc",   72'(IDLE_C), 72'(xgmii_txc));
    tick();
    tick();
    rx_rst_tb = 1'b0;
    tick();
    tick();
    expect_val("ar_after_state", 72'(3'd0), 72'(state));
    expect_val("ar_after_retry", 72'(2'd0), 72'(retry_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
